multicycle_controller: RTL and testbench
========================================

# multicycle_controller

Multicycle MIPS main control unit: a Moore state machine that sequences a shared-memory, single-ALU datapath through fetch, decode, execute, memory and write-back steps. It consumes the 6-bit opcode from the instruction register and a memory-ready handshake. It drives every datapath mux select, write enable and ALU operation class. It replaces single-cycle control when the datapath is folded onto one memory port and one ALU.

## Interface
Parameters:
- CNT_W, 32, width of retired-instruction counter

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- Op  in  6  opcode, IR[31:26]; valid from DECODE onward
- mem_ready  in  1  memory has completed the current read/write this cycle
- PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, ALUSrcA, RegWrite, RegDst  out  1 each  datapath controls
- PCSource  out  2  00 ALU result, 01 ALUOut, 10 jump target
- ALUSrcB  out  2  00 reg B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
- ALUOp  out  2  00 add, 01 subtract, 10 funct-decoded
- illegal_op  out  1  one-cycle pulse: unsupported opcode decoded
- instr_count  out  CNT_W  instructions retired since reset
- state  out  4  current state, for debug/trace

## Operation
- Opcodes: R 000000, LW 100011, SW 101011, BEQ 000100, J 000010. Any other value is illegal.
- States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, JUMP 9. Codes 10–15 are unreachable and recover to FETCH on the next edge.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
  - IRWrite and PCWrite equal mem_ready.
  - Advance to DECODE when mem_ready=1; otherwise hold.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target into ALUOut). Next state by opcode:
  - LW/SW → MEMADR; R → EXEC; BEQ → BRANCH; J → JUMP.
  - Illegal → FETCH, with illegal_op=1 in this cycle.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next: LW → MEMRD, SW → MEMWR.
- MEMRD: MemRead=1, IorD=1. Hold until mem_ready, then → MEMWB.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0. → FETCH.
- MEMWR: MemWrite=1, IorD=1. Hold until mem_ready, then → FETCH.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10. → ALUWB.
- ALUWB: RegWrite=1, MemtoReg=0, RegDst=1. → FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01. → FETCH.
- JUMP: PCWrite=1, PCSource=10. → FETCH.
- Any control not listed for a state is 0.
- instr_count increments by 1 on the final edge of each legal instruction, i.e. leaving MEMWB, ALUWB, BRANCH, JUMP, or MEMWR with mem_ready=1. It wraps modulo 2^CNT_W. Illegal opcodes are not counted.

## Timing
- rst_n low, at any time including mid-instruction: state=FETCH, instr_count=0, illegal_op=0.
  - While rst_n=0 all control outputs are forced to 0. This includes MemRead, so no memory access occurs during reset.
- First fetch begins in the first cycle after rst_n deasserts.
- Outputs are combinational from the registered state, plus mem_ready for IRWrite/PCWrite. No output depends on Op except illegal_op.
- Cycles per instruction with mem_ready tied high: LW 5, SW 4, R 4, BEQ 3, J 3, illegal 2. Each low mem_ready cycle in FETCH, MEMRD or MEMWR adds one cycle.
- mem_ready is ignored in every state other than FETCH, MEMRD and MEMWR.
- Op must be stable from DECODE until the instruction returns to FETCH. The IR changes only on IRWrite.

## Structure
- Shared package mips_pkg holds:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J);
  - the state enum with the encodings above;
  - ALUOp, ALUSrcB and PCSource encodings.
- Sub-module mc_ctrl_decode: pure combinational state → control-word decode, including the mem_ready gating in FETCH.
- The top module holds the state register, next-state logic, illegal_op and instr_count.

## Test plan
- Reset mid-instruction: assert rst_n low while in MEMRD → state=0 and all controls 0 immediately. On release, FETCH has MemRead=1.
- LW, mem_ready=1: Op=100011 → states 0,1,2,3,4,0. RegWrite=1 and MemtoReg=1 in cycle 5. instr_count 0→1.
- SW with memory wait: Op=101011, mem_ready low 3 cycles in MEMWR → MemWrite held 4 cycles, 7 cycles total. Count increments once.
- R-type then BEQ back-to-back: ALUOp=10 in EXEC, then ALUOp=01, PCWriteCond=1, PCSource=01 in BRANCH → count=2 after 7 cycles.
- J plus illegal: Op=000010 → PCWrite=1, PCSource=10 in cycle 3. Then Op=111111 → illegal_op pulses 1 cycle in DECODE, return to FETCH, count unchanged.
- FETCH stall: mem_ready=0 for 5 cycles → IRWrite=PCWrite=0 throughout, state stays 0. Both assert on the cycle mem_ready=1.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS control unit: opcodes,
// state encodings, datapath select encodings and the control word.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9
    } state_t;

    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_SUB    = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

    localparam logic [1:0] SRCB_REGB    = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Every datapath control driven by the state machine.
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       ir_write;
        logic       alu_src_a;
        logic       reg_write;
        logic       reg_dst;
        logic [1:0] pc_source;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
    } ctrl_t;

    function automatic logic is_legal_op(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_J);
    endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Moore output decode: registered state (plus mem_ready in FETCH) to control word.
module mc_ctrl_decode
    import mips_pkg::*;
(
    input  state_t state_i,
    input  logic   mem_ready_i,
    output ctrl_t  ctrl_o
);

    // Per-state control word; anything not set stays 0, including unreachable codes.
    always_comb begin
        ctrl_o = '0;
        case (state_i)
            S_FETCH: begin
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.alu_src_b = SRCB_FOUR;
                ctrl_o.alu_op    = ALUOP_ADD;
                ctrl_o.pc_source = PCSRC_ALU;
                // IR and PC update only once memory delivers the instruction.
                ctrl_o.ir_write  = mem_ready_i;
                ctrl_o.pc_write  = mem_ready_i;
            end
            S_DECODE: begin
                ctrl_o.alu_src_b = SRCB_IMM_SH2;
                ctrl_o.alu_op    = ALUOP_ADD;
            end
            S_MEMADR: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = ALUOP_ADD;
            end
            S_MEMRD: begin
                ctrl_o.mem_read = 1'b1;
                ctrl_o.i_or_d   = 1'b1;
            end
            S_MEMWB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                ctrl_o.mem_write = 1'b1;
                ctrl_o.i_or_d    = 1'b1;
            end
            S_EXEC: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_REGB;
                ctrl_o.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                ctrl_o.alu_src_a     = 1'b1;
                ctrl_o.alu_src_b     = SRCB_REGB;
                ctrl_o.alu_op        = ALUOP_SUB;
                ctrl_o.pc_write_cond = 1'b1;
                ctrl_o.pc_source     = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                ctrl_o.pc_write  = 1'b1;
                ctrl_o.pc_source = PCSRC_JUMP;
            end
            default: ctrl_o = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle MIPS main control: state register, sequencing, illegal-opcode
// flag and retired-instruction counter. Controls are forced low in reset.
module multicycle_controller
    import mips_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       Op,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             MemtoReg,
    output logic             IRWrite,
    output logic             ALUSrcA,
    output logic             RegWrite,
    output logic             RegDst,
    output logic [1:0]       PCSource,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic             illegal_op,
    output logic [CNT_W-1:0] instr_count,
    output logic [3:0]       state
);

    state_t           state_q;
    logic [CNT_W-1:0] count_q;
    ctrl_t            ctrl_raw;
    ctrl_t            ctrl_gated;

    mc_ctrl_decode u_decode (
        .state_i     (state_q),
        .mem_ready_i (mem_ready),
        .ctrl_o      (ctrl_raw)
    );

    // State sequencing and retire counting; unreachable codes fall back to FETCH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            count_q <= '0;
        end else begin
            case (state_q)
                S_FETCH:  if (mem_ready) state_q <= S_DECODE;
                S_DECODE: begin
                    if ((Op == OP_LW) || (Op == OP_SW)) state_q <= S_MEMADR;
                    else if (Op == OP_RTYPE)            state_q <= S_EXEC;
                    else if (Op == OP_BEQ)              state_q <= S_BRANCH;
                    else if (Op == OP_J)                state_q <= S_JUMP;
                    else                                state_q <= S_FETCH;
                end
                S_MEMADR: state_q <= (Op == OP_LW) ? S_MEMRD : S_MEMWR;
                S_MEMRD:  if (mem_ready) state_q <= S_MEMWB;
                S_MEMWB: begin
                    state_q <= S_FETCH;
                    count_q <= count_q + 1'b1;
                end
                S_MEMWR: begin
                    if (mem_ready) begin
                        state_q <= S_FETCH;
                        count_q <= count_q + 1'b1;
                    end
                end
                S_EXEC:   state_q <= S_ALUWB;
                S_ALUWB, S_BRANCH, S_JUMP: begin
                    state_q <= S_FETCH;
                    count_q <= count_q + 1'b1;
                end
                default:  state_q <= S_FETCH;
            endcase
        end
    end

    // Hold every control low while reset is asserted so no memory access can start.
    always_comb begin
        ctrl_gated = rst_n ? ctrl_raw : '0;
    end

    assign PCWrite     = ctrl_gated.pc_write;
    assign PCWriteCond = ctrl_gated.pc_write_cond;
    assign IorD        = ctrl_gated.i_or_d;
    assign MemRead     = ctrl_gated.mem_read;
    assign MemWrite    = ctrl_gated.mem_write;
    assign MemtoReg    = ctrl_gated.mem_to_reg;
    assign IRWrite     = ctrl_gated.ir_write;
    assign ALUSrcA     = ctrl_gated.alu_src_a;
    assign RegWrite    = ctrl_gated.reg_write;
    assign RegDst      = ctrl_gated.reg_dst;
    assign PCSource    = ctrl_gated.pc_source;
    assign ALUSrcB     = ctrl_gated.alu_src_b;
    assign ALUOp       = ctrl_gated.alu_op;

    assign illegal_op  = rst_n && (state_q == S_DECODE) && !is_legal_op(Op);
    assign instr_count = count_q;
    assign state       = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench: each instruction is expanded from its opcode and wait
// counts into the expected per-cycle step list, then checked cycle by cycle.
module tb_multicycle_controller;

    localparam int ST_FETCH = 0, ST_DECODE = 1, ST_MEMADR = 2, ST_MEMRD = 3,
                   ST_MEMWB = 4, ST_MEMWR = 5, ST_EXEC = 6, ST_ALUWB = 7,
                   ST_BRANCH = 8, ST_JUMP = 9;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  Op;
    logic        mem_ready;
    logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg;
    logic        IRWrite, ALUSrcA, RegWrite, RegDst;
    logic [1:0]  PCSource, ALUSrcB, ALUOp;
    logic        illegal_op;
    logic [31:0] instr_count;
    logic [3:0]  state;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] exp_cnt  = 0;
    int          n_instr  = 0;

    multicycle_controller #(.CNT_W(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .Op          (Op),
        .mem_ready   (mem_ready),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .IorD        (IorD),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .MemtoReg    (MemtoReg),
        .IRWrite     (IRWrite),
        .ALUSrcA     (ALUSrcA),
        .RegWrite    (RegWrite),
        .RegDst      (RegDst),
        .PCSource    (PCSource),
        .ALUSrcB     (ALUSrcB),
        .ALUOp       (ALUOp),
        .illegal_op  (illegal_op),
        .instr_count (instr_count),
        .state       (state)
    );

    always #5 clk = ~clk;

    wire [15:0] ctrl_w = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg,
                          IRWrite, ALUSrcA, RegWrite, RegDst, PCSource, ALUSrcB, ALUOp};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic bit legal(input logic [5:0] op);
        return op == 6'b000000 || op == 6'b100011 || op == 6'b101011 ||
               op == 6'b000100 || op == 6'b000010;
    endfunction

    // Control table straight from the per-state behaviour description.
    function automatic logic [15:0] exp_ctrl(input int st, input logic mr);
        logic pcw = 0, pcwc = 0, iord = 0, mrd = 0, mwr = 0, m2r = 0;
        logic irw = 0, srca = 0, rw = 0, rdst = 0;
        logic [1:0] pcs = 0, srcb = 0, aop = 0;
        case (st)
            ST_FETCH:  begin mrd = 1; srcb = 2'b01; irw = mr; pcw = mr; end
            ST_DECODE: srcb = 2'b11;
            ST_MEMADR: begin srca = 1; srcb = 2'b10; end
            ST_MEMRD:  begin mrd = 1; iord = 1; end
            ST_MEMWB:  begin rw = 1; m2r = 1; end
            ST_MEMWR:  begin mwr = 1; iord = 1; end
            ST_EXEC:   begin srca = 1; aop = 2'b10; end
            ST_ALUWB:  begin rw = 1; rdst = 1; end
            ST_BRANCH: begin srca = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
            ST_JUMP:   begin pcw = 1; pcs = 2'b10; end
            default: ;
        endcase
        return {pcw, pcwc, iord, mrd, mwr, m2r, irw, srca, rw, rdst, pcs, srcb, aop};
    endfunction

    // One clock cycle: drive inputs after the falling edge, check just after.
    task automatic do_cycle(input int st, input logic mr, input logic [5:0] op);
        @(negedge clk);
        mem_ready = mr;
        Op        = op;
        #1;
        check("state", state, st);
        check("ctrl", ctrl_w, exp_ctrl(st, mr));
        check("illegal_op", illegal_op, (st == ST_DECODE) && !legal(op));
        check("instr_count", instr_count, exp_cnt);
    endtask

    // Expand one instruction into its expected step list and run it.
    task automatic run_instr(input logic [5:0] op, input int fw, input int mw);
        int cyc = 0;
        for (int i = 0; i < fw; i++) begin
            do_cycle(ST_FETCH, 1'b0, 6'($urandom)); cyc++;
        end
        do_cycle(ST_FETCH, 1'b1, op);                 cyc++;
        do_cycle(ST_DECODE, 1'($urandom), op);        cyc++;
        if (op == 6'b100011 || op == 6'b101011) begin
            do_cycle(ST_MEMADR, 1'($urandom), op);    cyc++;
            for (int i = 0; i < mw; i++) begin
                do_cycle(op == 6'b100011 ? ST_MEMRD : ST_MEMWR, 1'b0, op); cyc++;
            end
            if (op == 6'b100011) begin
                do_cycle(ST_MEMRD, 1'b1, op);         cyc++;
                do_cycle(ST_MEMWB, 1'($urandom), op); cyc++;
            end else begin
                do_cycle(ST_MEMWR, 1'b1, op);         cyc++;
            end
        end else if (op == 6'b000000) begin
            do_cycle(ST_EXEC, 1'($urandom), op);      cyc++;
            do_cycle(ST_ALUWB, 1'($urandom), op);     cyc++;
        end else if (op == 6'b000100) begin
            do_cycle(ST_BRANCH, 1'($urandom), op);    cyc++;
        end else if (op == 6'b000010) begin
            do_cycle(ST_JUMP, 1'($urandom), op);      cyc++;
        end
        if (legal(op)) exp_cnt++;
        n_instr++;
        $display("instr %0d op=%06b fetch_wait=%0d mem_wait=%0d cycles=%0d expected_count=%0d",
                 n_instr, op, fw, mw, cyc, exp_cnt);
    endtask

    initial begin
        logic [5:0] ops [5];
        ops[0] = 6'b000000; ops[1] = 6'b100011; ops[2] = 6'b101011;
        ops[3] = 6'b000100; ops[4] = 6'b000010;

        rst_n = 1'b0; mem_ready = 1'b1; Op = 6'b100011;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        check("reset_state", state, 0);
        check("reset_ctrl", ctrl_w, 0);
        check("reset_count", instr_count, 0);
        check("reset_illegal", illegal_op, 0);
        @(negedge clk);
        rst_n = 1'b1; mem_ready = 1'b0;

        // Directed scenarios.
        run_instr(6'b100011, 0, 0);  // LW, no waits: 5 cycles
        run_instr(6'b101011, 0, 3);  // SW, three wait cycles in MEMWR: 7 cycles
        run_instr(6'b000000, 0, 0);  // R-type
        run_instr(6'b000100, 0, 0);  // BEQ back-to-back
        run_instr(6'b000010, 0, 0);  // J
        run_instr(6'b111111, 0, 0);  // illegal, not counted
        run_instr(6'b000010, 5, 0);  // FETCH stall of 5 cycles

        // Randomized mix of legal and arbitrary opcodes with random waits.
        for (int n = 0; n < 200; n++) begin
            logic [5:0] op;
            op = ($urandom_range(0, 5) == 5) ? 6'($urandom) : ops[$urandom_range(0, 4)];
            run_instr(op, $urandom_range(0, 3), $urandom_range(0, 3));
        end

        // Reset in the middle of a stalled LW read.
        do_cycle(ST_FETCH, 1'b1, 6'b100011);
        do_cycle(ST_DECODE, 1'b1, 6'b100011);
        do_cycle(ST_MEMADR, 1'b1, 6'b100011);
        do_cycle(ST_MEMRD, 1'b0, 6'b100011);
        @(negedge clk);
        mem_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        exp_cnt = 0;
        check("midreset_state", state, 0);
        check("midreset_ctrl", ctrl_w, 0);
        check("midreset_count", instr_count, 0);
        check("midreset_illegal", illegal_op, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_instr(6'b000010, 0, 0);
        run_instr(6'b100011, 1, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, got %0d checks expected completion", n_checks);
        $fatal(1, "timeout");
    end

endmodule
